control_unit_mc: RTL

- Multicycle, parametrised successor to the single-cycle control unit of the microc CPU.
- Sequences each instruction through an instruction-fetch handshake and a one-cycle execute phase.
- Drives the existing datapath controls (s_inc, s_inm, we, wez, ALUOp). Adds a PC write enable, CALL/RET through an internal return-address stack, HALT, and illegal-opcode/stack error reporting.
- Sits between instruction memory, the PC logic and the datapath register file/ALU.

---
 rtl/control_unit_mc.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/control_unit_mc.sv
// Multicycle control unit: fetch handshake, one-cycle execute, return-address stack.
// state | meaning
// FETCH | request instruction, latch Opcode into IR on imem_ack
// EXEC  | drive datapath controls decoded from IR for one cycle
// HALT  | all strobes idle until reset
module control_unit_mc #(
    parameter int PCW         = 10,
    parameter int STACK_DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           imem_ack,
    input  logic [5:0]     Opcode,
    input  logic           zero,
    input  logic [PCW-1:0] pc_plus1,
    output logic           imem_req,
    output logic           pc_we,
    output logic           s_inc,
    output logic           s_ret,
    output logic           s_inm,
    output logic           we,
    output logic           wez,
    output logic [2:0]     ALUOp,
    output logic [PCW-1:0] ret_addr,
    output logic           halted,
    output logic           illegal,
    output logic           stack_err
);

    localparam int SPW   = $clog2(STACK_DEPTH + 1);
    localparam int SLOTS = 1 << SPW;

    typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;

    state_t         state, state_nxt;
    logic [5:0]     ir;
    logic [SPW-1:0] sp;
    logic [PCW-1:0] stack_mem [SLOTS];
    logic           err_q;
    logic           stack_empty, stack_full;
    logic           is_call, is_ret;
    logic [PCW-1:0] top;

    assign stack_empty = (sp == '0);
    assign stack_full  = (sp == SPW'(STACK_DEPTH));
    assign top         = stack_empty ? '0 : stack_mem[sp - SPW'(1)];
    assign is_call     = (state == EXEC) && (ir == 6'b011_000);
    assign is_ret      = (state == EXEC) && (ir == 6'b011_001);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= FETCH;
            ir    <= '0;
            sp    <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == FETCH && imem_ack)
                ir <= Opcode;
            // A full-stack CALL still jumps; only the push is lost.
            if (is_call) begin
                if (!stack_full) begin
                    stack_mem[sp] <= pc_plus1;
                    sp            <= sp + SPW'(1);
                end else begin
                    err_q <= 1'b1;
                end
            end
            if (is_ret) begin
                if (!stack_empty)
                    sp <= sp - SPW'(1);
                else
                    err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        pc_we     = 1'b0;
        s_inc     = 1'b1;
        s_ret     = 1'b0;
        s_inm     = 1'b0;
        we        = 1'b0;
        wez       = 1'b0;
        ALUOp     = 3'b000;
        halted    = 1'b0;
        illegal   = 1'b0;
        ret_addr  = top;
        stack_err = err_q;

        case (state)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack)
                    state_nxt = EXEC;
            end
            EXEC: begin
                state_nxt = (ir[5:3] == 3'b111) ? HALT : FETCH;
                pc_we     = 1'b1;
                case (ir[5:3])
                    3'b000: begin
                        we    = 1'b1;
                        wez   = 1'b1;
                        ALUOp = ir[2:0];
                    end
                    3'b001: begin
                        we    = 1'b1;
                        s_inm = 1'b1;
                    end
                    3'b010: begin
                        case (ir[2:0])
                            3'b000:  s_inc   = 1'b0;
                            3'b001:  s_inc   = ~zero;
                            3'b010:  s_inc   = zero;
                            default: illegal = 1'b1;
                        endcase
                    end
                    3'b011: begin
                        case (ir[2:0])
                            3'b000:  s_inc   = 1'b0;
                            3'b001:  s_ret   = ~stack_empty;
                            default: illegal = 1'b1;
                        endcase
                    end
                    3'b111:  pc_we   = 1'b0;
                    default: illegal = 1'b1;
                endcase
            end
            HALT: halted = 1'b1;
            default: state_nxt = FETCH;
        endcase

        // Outputs are held at their idle values for as long as reset is low.
        if (!reset) begin
            imem_req  = 1'b0;
            pc_we     = 1'b0;
            s_inc     = 1'b1;
            s_ret     = 1'b0;
            s_inm     = 1'b0;
            we        = 1'b0;
            wez       = 1'b0;
            ALUOp     = 3'b000;
            halted    = 1'b0;
            illegal   = 1'b0;
            ret_addr  = '0;
            stack_err = 1'b0;
        end
    end

endmodule
